// File: rtl/relm_i2c_pkg.sv
// Shared types and constants for the relm I2C target: FSM states and pop_q flag positions.
package relm_i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StWr,
    StWrAck,
    StRd,
    StRdAck
  } state_t;

  // Flag bit positions in pop_q, counted down from bit WD
  localparam int unsigned StopFlagOfs = 1;
  localparam int unsigned WrFlagOfs   = 2;
  localparam int unsigned RdFlagOfs   = 3;
  localparam int unsigned BusyOfs     = 4;

  localparam logic [6:0] GenCallAddr = 7'h00;

endpackage

// File: rtl/relm_i2c_if.sv
// Core-side push/pop bus of the relm I2C target, in [WD:0] relm format (bit WD = strobe).
interface relm_i2c_if #(
  parameter int unsigned WD = 32
);
  logic [WD:0] push_d;
  logic        push_retry;
  logic [WD:0] pop_d;
  logic [WD:0] pop_q;

  modport master (output push_d, pop_d, input push_retry, pop_q);
  modport slave  (input push_d, pop_d, output push_retry, pop_q);
endinterface

// File: rtl/relm_i2c_sync.sv
// Two-flop synchronisers for SCL/SDA plus a third flop for edge, START and STOP detection.
module relm_i2c_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);
  // [1] is the synchronised level, [2] the same level one clk older
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign sda_s    = sda_q[1];

endmodule

// File: rtl/relm_i2c_target.sv
// I2C target exposing a 2**WRA x 8 register file to an external master and to the relm core.
module relm_i2c_target
  import relm_i2c_pkg::*;
#(
  parameter int unsigned WD       = 32,
  parameter int unsigned WRA      = 4,
  parameter logic [6:0]  I2C_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe_out,
  relm_i2c_if.slave  bus
);
  localparam int unsigned NReg = 2 ** WRA;

  logic scl_rise, scl_fall, start, stop, sda_s;

  relm_i2c_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [WRA-1:0] ptr_q, ptr_d, ptr_inc;
  logic           rw_q, rw_d, matched_q, matched_d, sda_oe_q, sda_oe_d;
  logic           stop_f_q, stop_f_d, wr_f_q, wr_f_d, rd_f_q, rd_f_d;
  logic [7:0]     regs_q [NReg];
  logic [7:0]     regs_d [NReg];
  logic [7:0]     byte_in;
  logic           i2c_we, set_stop, set_wr, set_rd;

  assign byte_in = {shift_q[6:0], sda_s};
  assign ptr_inc = ptr_q + WRA'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    matched_d = matched_q;
    sda_oe_d  = sda_oe_q;
    i2c_we    = 1'b0;
    set_stop  = 1'b0;
    set_wr    = 1'b0;
    set_rd    = 1'b0;
    if (stop) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      set_stop  = matched_q;
      matched_d = 1'b0;
    end else if (start) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr, StPtr, StWr: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StAddr) begin
                if (byte_in[7:1] == I2C_ADDR && byte_in[7:1] != GenCallAddr) begin
                  state_d   = StAddrAck;
                  rw_d      = byte_in[0];
                  matched_d = 1'b1;
                end else begin
                  state_d = StIdle;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = byte_in[WRA-1:0];
                state_d = StWrAck;
              end else begin
                i2c_we  = 1'b1;
                ptr_d   = ptr_inc;
                set_wr  = 1'b1;
                state_d = StWrAck;
              end
            end
          end
        end
        // First fall drives ACK, second fall ends it
        StAddrAck, StWrAck: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == StAddrAck && rw_q) begin
              state_d  = StRd;
              shift_d  = regs_q[ptr_q] << 1;
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              state_d  = (state_q == StAddrAck) ? StPtr : StWr;
              sda_oe_d = 1'b0;
            end
          end
        end
        StRd: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = shift_q << 1;
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = StRdAck;
          end
        end
        StRdAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            ptr_d     = ptr_inc;
            bit_cnt_d = '0;
            if (!sda_s) begin
              state_d = StRd;
              shift_d = regs_q[ptr_inc];
            end else begin
              state_d = StIdle;
              set_rd  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (bus.push_d[WD]) regs_d[bus.push_d[8 +: WRA]] = bus.push_d[7:0];
    // Applied last so the I2C write wins a same-index collision
    if (i2c_we) regs_d[ptr_q] = byte_in;
  end

  always_comb begin
    stop_f_d = stop_f_q;
    wr_f_d   = wr_f_q;
    rd_f_d   = rd_f_q;
    if (bus.pop_d[WD]) begin
      stop_f_d = 1'b0;
      wr_f_d   = 1'b0;
      rd_f_d   = 1'b0;
    end
    if (set_stop) stop_f_d = 1'b1;
    if (set_wr)   wr_f_d   = 1'b1;
    if (set_rd)   rd_f_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      matched_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      stop_f_q  <= 1'b0;
      wr_f_q    <= 1'b0;
      rd_f_q    <= 1'b0;
      regs_q    <= '{default: 8'h00};
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      matched_q <= matched_d;
      sda_oe_q  <= sda_oe_d;
      stop_f_q  <= stop_f_d;
      wr_f_q    <= wr_f_d;
      rd_f_q    <= rd_f_d;
      regs_q    <= regs_d;
    end
  end

  assign sda_oe_out     = sda_oe_q;
  assign bus.push_retry = 1'b0;

  always_comb begin
    bus.pop_q                 = '0;
    bus.pop_q[7:0]            = regs_q[bus.pop_d[8 +: WRA]];
    bus.pop_q[WD-StopFlagOfs] = stop_f_q;
    bus.pop_q[WD-WrFlagOfs]   = wr_f_q;
    bus.pop_q[WD-RdFlagOfs]   = rd_f_q;
    bus.pop_q[WD-BusyOfs]     = (state_q != StIdle);
  end

  logic unused_bus;
  assign unused_bus = ^{bus.push_d[WD-1:8+WRA], bus.pop_d[WD-1:8+WRA], bus.pop_d[7:0]};

endmodule
